// File: rtl/demorgan_pkg.sv
// Shared constants for the De Morgan logic unit: operating modes, FSM encodings
// and the size of the built-in self-test sweep.
package demorgan_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ANDN_IN = 2'b00,  // ~A & ~B
        MODE_ORN_IN  = 2'b01,  // ~A | ~B
        MODE_NOR     = 2'b10,  // ~(A | B)
        MODE_NAND    = 2'b11   // ~(A & B)
    } mode_e;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_EMPTY = 3'd1;
    localparam logic [2:0] ST_SWEEP      = 3'd2;
    localparam logic [2:0] ST_DRAIN      = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    localparam int NUM_ST_VEC = 16;
    localparam int ST_IDX_W   = $clog2(NUM_ST_VEC);

endpackage

// File: rtl/demorgan_unit_if.sv
// Valid/ready operand and result channels of the De Morgan unit.
interface demorgan_unit_if
    import demorgan_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [MODE_W-1:0] in_mode;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_na;
    logic [WIDTH-1:0]  out_nb;
    logic [WIDTH-1:0]  out_y;
    logic              out_eq;

    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready,
        input  in_ready, out_valid, out_na, out_nb, out_y, out_eq
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready,
        output in_ready, out_valid, out_na, out_nb, out_y, out_eq
    );
endinterface

// File: rtl/demorgan_core.sv
// Combinational primary form, De Morgan dual form and their equality check.
module demorgan_core
    import demorgan_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [MODE_W-1:0] mode,
    input  logic              fault_inj,
    output logic [WIDTH-1:0]  na,
    output logic [WIDTH-1:0]  nb,
    output logic [WIDTH-1:0]  y,
    output logic              eq
);
    logic [WIDTH-1:0] dual;
    logic [WIDTH-1:0] dual_f;

    always_comb begin
        na   = ~a;
        nb   = ~b;
        y    = '0;
        dual = '0;
        case (mode)
            MODE_ANDN_IN: begin y = ~a & ~b;   dual = ~(a | b); end
            MODE_ORN_IN:  begin y = ~a | ~b;   dual = ~(a & b); end
            MODE_NOR:     begin y = ~(a | b);  dual = ~a & ~b;  end
            default:      begin y = ~(a & b);  dual = ~a | ~b;  end
        endcase
        // Flipping one dual bit lets the mismatch/error path be exercised on demand
        dual_f    = dual;
        dual_f[0] = dual[0] ^ fault_inj;
        eq        = (y == dual_f);
    end
endmodule

// File: rtl/demorgan_unit.sv
// Two-stage elastic De Morgan unit with mismatch counter and a 16-vector
// self-test sweep that borrows the pipeline while external input is held off.
module demorgan_unit
    import demorgan_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    demorgan_unit_if.slave   bus,
    input  logic             fault_inj,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag,
    input  logic             selftest_start,
    output logic             selftest_busy,
    output logic             selftest_done,
    output logic             selftest_pass
);
    logic [2:0]          state_q, state_d;
    logic [ST_IDX_W-1:0] idx_q, idx_d;

    logic                s1_v_q, s1_v_d;
    logic [WIDTH-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [MODE_W-1:0]   s1_mode_q, s1_mode_d;

    logic                s2_v_q, s2_v_d;
    logic [WIDTH-1:0]    s2_na_q, s2_na_d, s2_nb_q, s2_nb_d, s2_y_q, s2_y_d;
    logic                s2_eq_q, s2_eq_d;

    logic [CNT_W-1:0]    err_count_q, err_count_d;
    logic                err_flag_q, err_flag_d;
    logic                done_q, done_d, pass_q, pass_d;
    logic                sweep_err_q, sweep_err_d;

    logic [WIDTH-1:0]    core_na, core_nb, core_y;
    logic                core_eq;
    logic                sweep_mode, s2_adv, s1_adv, in_ready, accept, inject;
    logic                retire, mismatch, pipe_empty;

    demorgan_core #(.WIDTH(WIDTH)) u_core (
        .a        (s1_a_q),
        .b        (s1_b_q),
        .mode     (s1_mode_q),
        .fault_inj(fault_inj),
        .na       (core_na),
        .nb       (core_nb),
        .y        (core_y),
        .eq       (core_eq)
    );

    always_comb begin
        sweep_mode = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
        s2_adv     = !s2_v_q || bus.out_ready || sweep_mode;
        s1_adv     = !s1_v_q || s2_adv;
        in_ready   = s1_adv && (state_q == ST_IDLE);
        accept     = bus.in_valid && in_ready;
        inject     = (state_q == ST_SWEEP);
        retire     = s2_v_q && s2_adv;
        mismatch   = retire && !s2_eq_q;
        pipe_empty = !s1_v_q && !s2_v_q;

        s1_v_d    = s1_v_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
        s1_mode_d = s1_mode_q;
        if (s1_adv) begin
            s1_v_d = accept || inject;
            if (inject) begin
                // Sweep index is {mode, a_bit, b_bit}; operands are bit-replicated
                s1_a_d    = {WIDTH{idx_q[1]}};
                s1_b_d    = {WIDTH{idx_q[0]}};
                s1_mode_d = idx_q[3:2];
            end else if (accept) begin
                s1_a_d    = bus.in_a;
                s1_b_d    = bus.in_b;
                s1_mode_d = bus.in_mode;
            end
        end

        s2_v_d  = s2_v_q;
        s2_na_d = s2_na_q;
        s2_nb_d = s2_nb_q;
        s2_y_d  = s2_y_q;
        s2_eq_d = s2_eq_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_na_d = core_na;
                s2_nb_d = core_nb;
                s2_y_d  = core_y;
                s2_eq_d = core_eq;
            end
        end

        err_count_d = err_count_q;
        err_flag_d  = err_flag_q;
        if (err_clr) begin
            err_count_d = '0;
            err_flag_d  = 1'b0;
        end else if (mismatch) begin
            if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + CNT_W'(1);
            err_flag_d = 1'b1;
        end

        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = done_q;
        pass_d      = pass_q;
        sweep_err_d = sweep_err_q || (sweep_mode && mismatch);
        case (state_q)
            ST_IDLE: if (selftest_start) begin
                state_d = ST_WAIT_EMPTY;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
            ST_WAIT_EMPTY: if (pipe_empty) begin
                state_d     = ST_SWEEP;
                idx_d       = '0;
                sweep_err_d = 1'b0;
            end
            ST_SWEEP: begin
                idx_d = idx_q + ST_IDX_W'(1);
                if (idx_q == ST_IDX_W'(NUM_ST_VEC - 1)) state_d = ST_DRAIN;
            end
            ST_DRAIN: if (pipe_empty) begin
                // Last sweep beat has already retired, so sweep_err_q is final
                state_d = ST_DONE;
                done_d  = 1'b1;
                pass_d  = !sweep_err_q;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            s1_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_mode_q   <= '0;
            s2_v_q      <= 1'b0;
            s2_na_q     <= '0;
            s2_nb_q     <= '0;
            s2_y_q      <= '0;
            s2_eq_q     <= 1'b0;
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            sweep_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            s1_v_q      <= s1_v_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_mode_q   <= s1_mode_d;
            s2_v_q      <= s2_v_d;
            s2_na_q     <= s2_na_d;
            s2_nb_q     <= s2_nb_d;
            s2_y_q      <= s2_y_d;
            s2_eq_q     <= s2_eq_d;
            err_count_q <= err_count_d;
            err_flag_q  <= err_flag_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            sweep_err_q <= sweep_err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = s2_v_q && !sweep_mode;
    assign bus.out_na     = s2_na_q;
    assign bus.out_nb     = s2_nb_q;
    assign bus.out_y      = s2_y_q;
    assign bus.out_eq     = s2_eq_q;
    assign err_count      = err_count_q;
    assign err_flag       = err_flag_q;
    assign selftest_busy  = (state_q == ST_WAIT_EMPTY) || sweep_mode;
    assign selftest_done  = done_q;
    assign selftest_pass  = pass_q;
endmodule

// File: tb/tb_demorgan_unit.sv
// Scoreboard bench for demorgan_unit: expected beats are queued on acceptance
// and checked in order as results leave the pipeline.
module tb_demorgan_unit;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] na;
        logic [W-1:0] nb;
        logic [W-1:0] y;
        logic         eq;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fault_inj, err_clr, st_start;
    logic [7:0] err_count;
    logic       err_flag, st_busy, st_done, st_pass;
    logic [1:0] err_count2;
    logic       err_flag2, st_busy2, st_done2, st_pass2;

    beat_t sb_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    demorgan_unit_if #(.WIDTH(W)) bus();
    demorgan_unit_if #(.WIDTH(W)) bus2();

    demorgan_unit #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .fault_inj(fault_inj), .err_clr(err_clr),
        .err_count(err_count), .err_flag(err_flag),
        .selftest_start(st_start), .selftest_busy(st_busy),
        .selftest_done(st_done), .selftest_pass(st_pass)
    );

    demorgan_unit #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .fault_inj(1'b1), .err_clr(1'b0),
        .err_count(err_count2), .err_flag(err_flag2),
        .selftest_start(1'b0), .selftest_busy(st_busy2),
        .selftest_done(st_done2), .selftest_pass(st_pass2)
    );

    // Reference: mode bit 0 selects NAND-of-inputs, otherwise NOR-of-inputs
    function automatic beat_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] m, input logic f);
        beat_t r;
        r.na = ~a;
        r.nb = ~b;
        for (int i = 0; i < W; i++) r.y[i] = m[0] ? !(a[i] && b[i]) : !(a[i] || b[i]);
        r.eq = !f;
        return r;
    endfunction

    task automatic cycle(output bit acc, output bit got, output beat_t exp, output beat_t act);
        @(negedge clk);
        got = bus.out_valid && bus.out_ready;
        act = {bus.out_na, bus.out_nb, bus.out_y, bus.out_eq};
        exp = 'x;
        if (got && sb_q.size() > 0) exp = sb_q.pop_front();
        acc = bus.in_valid && bus.in_ready;
        if (acc) sb_q.push_back(model(bus.in_a, bus.in_b, bus.in_mode, fault_inj));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_mode  = m;
    endtask

    task automatic test_reset();
        bit acc, got; beat_t exp, act; int ngot = 0;
        n_cmp++;
        if ({bus.out_valid, err_count, err_flag, st_busy, st_done, st_pass} !== 13'd0) begin
            n_err++; $display("FAIL reset_state: got %b required 0", {bus.out_valid, err_count, err_flag, st_busy, st_done, st_pass});
        end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        fault_inj = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(W'($urandom), W'($urandom), 2'($urandom));
            cycle(acc, got, exp, act);
            if (got) begin
                ngot++; n_cmp++;
                if (act !== exp) begin n_err++; $display("FAIL reset_stream: got %h required %h", act, exp); end
            end
        end
        n_cmp++;
        if (err_count !== 8'(ngot)) begin n_err++; $display("FAIL reset_precount: got %0d required %0d", err_count, ngot); end
        #2 rst_n = 1'b0;
        bus.in_valid = 1'b0;
        fault_inj = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || err_count !== 8'd0) begin
            n_err++; $display("FAIL reset_midstream: out_valid=%b err_count=%0d required 0/0", bus.out_valid, err_count);
        end
        sb_q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta[2] = '{4'b0011, 4'b1010};
        logic [W-1:0] tb[2] = '{4'b0101, 4'b1100};
        logic [1:0]   tm[2] = '{2'b00, 2'b11};
        logic [W-1:0] ty[2] = '{4'b1000, 4'b0111};
        bit acc, got; beat_t exp, act; int lat;
        bus.out_ready = 1'b1;
        for (int v = 0; v < 2; v++) begin
            drive(ta[v], tb[v], tm[v]);
            lat = -1;
            for (int c = 0; c < 10; c++) begin
                cycle(acc, got, exp, act);
                if (lat >= 0) lat++;
                if (acc) begin lat = 0; bus.in_valid = 1'b0; end
                if (got) begin
                    n_cmp++;
                    if (act !== exp) begin n_err++; $display("FAIL basic_%0d: got %h required %h", v, act, exp); end
                    n_cmp++;
                    if (act.y !== ty[v] || act.eq !== 1'b1 || lat != 2) begin
                        n_err++; $display("FAIL basic_const_%0d: y=%b eq=%b lat=%0d required y=%b eq=1 lat=2", v, act.y, act.eq, lat, ty[v]);
                    end
                    break;
                end
                if (c == 9) begin n_cmp++; n_err++; $display("FAIL basic_timeout_%0d: no output, required one", v); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc, got; beat_t exp, act; int idx = 0, stalls = 0; bit done = 0;
        bus.out_ready = 1'b1;
        drive(W'($urandom), W'($urandom), 2'($urandom));
        for (int c = 0; c < 100; c++) begin
            cycle(acc, got, exp, act);
            if (acc) begin
                idx++;
                if (idx < 24) drive(W'($urandom), W'($urandom), 2'($urandom));
                else bus.in_valid = 1'b0;
            end else if (bus.in_valid) stalls++;
            if (got) begin
                n_cmp++;
                if (act !== exp) begin n_err++; $display("FAIL b2b_beat: got %h required %h", act, exp); end
            end
            if (idx == 24 && sb_q.size() == 0) begin done = 1; break; end
        end
        n_cmp++;
        if (!done || stalls != 0) begin n_err++; $display("FAIL b2b_throughput: done=%0d stalls=%0d required 1/0", done, stalls); end
    endtask

    task automatic test_stall();
        bit acc, got; beat_t exp, act; int nacc = 0;
        bus.out_ready = 1'b0;
        drive(4'h1, 4'h2, 2'b01);
        for (int c = 0; c < 5; c++) begin
            cycle(acc, got, exp, act);
            if (acc) begin nacc++; drive(W'(nacc + 1), W'(nacc * 3), 2'(nacc)); end
        end
        n_cmp++;
        if (nacc != 2 || bus.in_ready !== 1'b0) begin
            n_err++; $display("FAIL stall_accept: accepted=%0d in_ready=%b required 2/0", nacc, bus.in_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || {bus.out_na, bus.out_nb, bus.out_y, bus.out_eq} !== sb_q[0]) begin
            n_err++; $display("FAIL stall_hold: valid=%b data=%h required 1/%h", bus.out_valid, {bus.out_na, bus.out_nb, bus.out_y, bus.out_eq}, sb_q[0]);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cycle(acc, got, exp, act);
            if (acc) begin nacc++; bus.in_valid = 1'b0; end
            if (got) begin
                n_cmp++;
                if (act !== exp) begin n_err++; $display("FAIL stall_order: got %h required %h", act, exp); end
            end
            if (nacc == 3 && sb_q.size() == 0) break;
        end
        n_cmp++;
        if (nacc != 3 || sb_q.size() != 0) begin n_err++; $display("FAIL stall_drain: accepted=%0d left=%0d required 3/0", nacc, sb_q.size()); end
    endtask

    task automatic test_fault();
        bit acc, got; beat_t exp, act; int nacc;
        bus.out_ready = 1'b1;
        fault_inj = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            // Second pass holds err_clr so the clear must win over each increment
            err_clr = (pass == 1);
            nacc = 0;
            drive(4'h5, 4'h9, 2'b10);
            for (int c = 0; c < 20; c++) begin
                cycle(acc, got, exp, act);
                if (acc) begin nacc++; if (nacc == 3) bus.in_valid = 1'b0; end
                if (got) begin
                    n_cmp++;
                    if (act !== exp) begin n_err++; $display("FAIL fault_beat: got %h required %h", act, exp); end
                end
                if (nacc == 3 && sb_q.size() == 0) break;
            end
            n_cmp++;
            if (err_count !== (pass == 0 ? 8'd3 : 8'd0) || err_flag !== (pass == 0)) begin
                n_err++; $display("FAIL fault_count_%0d: count=%0d flag=%b", pass, err_count, err_flag);
            end
            if (pass == 0) begin
                err_clr = 1'b1;
                @(posedge clk); #1;
                err_clr = 1'b0;
                n_cmp++;
                if (err_count !== 8'd0 || err_flag !== 1'b0) begin
                    n_err++; $display("FAIL fault_clear: count=%0d flag=%b required 0/0", err_count, err_flag);
                end
            end
        end
        err_clr = 1'b0;
        fault_inj = 1'b0;
        bus2.in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus2.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (err_count2 !== 2'd3 || err_flag2 !== 1'b1) begin
            n_err++; $display("FAIL fault_saturate: count=%0d flag=%b required 3/1", err_count2, err_flag2);
        end
    endtask

    task automatic test_selftest();
        bit acc, got; beat_t exp, act; int ndel; bit fin;
        bus.out_ready = 1'b1;
        for (int run = 0; run < 2; run++) begin
            fault_inj = (run == 1);
            ndel = 0;
            fin = 0;
            if (run == 0) begin
                drive(4'h3, 4'hC, 2'b00);
                cycle(acc, got, exp, act);
                drive(4'h6, 4'h6, 2'b11);
                cycle(acc, got, exp, act);
                if (got) ndel++;
            end
            bus.in_valid = 1'b0;
            st_start = 1'b1;
            cycle(acc, got, exp, act);
            st_start = 1'b0;
            if (got) begin
                ndel++; n_cmp++;
                if (act !== exp) begin n_err++; $display("FAIL st_flush: got %h required %h", act, exp); end
            end
            n_cmp++;
            if (st_busy !== 1'b1 || bus.in_ready !== 1'b0 || st_done !== 1'b0) begin
                n_err++; $display("FAIL st_busy_%0d: busy=%b in_ready=%b done=%b required 1/0/0", run, st_busy, bus.in_ready, st_done);
            end
            for (int c = 0; c < 100; c++) begin
                cycle(acc, got, exp, act);
                if (got) begin
                    ndel++; n_cmp++;
                    if (act !== exp) begin n_err++; $display("FAIL st_flush: got %h required %h", act, exp); end
                end
                if (st_done) begin fin = 1; break; end
            end
            n_cmp++;
            if (!fin || st_pass !== (run == 0) || ndel != (run == 0 ? 2 : 0) || sb_q.size() != 0) begin
                n_err++; $display("FAIL st_result_%0d: done=%0d pass=%b delivered=%0d", run, fin, st_pass, ndel);
            end
            n_cmp++;
            if (err_count !== (run == 0 ? 8'd0 : 8'd16)) begin
                n_err++; $display("FAIL st_errcount_%0d: got %0d required %0d", run, err_count, (run == 0 ? 0 : 16));
            end
            cycle(acc, got, exp, act);
        end
        fault_inj = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        fault_inj = 1'b0; err_clr = 1'b0; st_start = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = '0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_mode = '0; bus2.out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_fault();
        test_selftest();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
